// File: rtl/imm_encode_loader.sv
// Packs a 32-bit immediate into RV32I instruction fields and streams the merged word with its write address.
// Two-stage elastic pipeline. Define IMM_RANGE_CHECK_EN to flag immediates that do not fit their format.
module imm_encode_loader #(
    parameter int address_width = 32,
    parameter int BASE_ADDR     = 0,
    parameter int DEPTH         = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [address_width-1:0] in_imm,
    input  logic [2:0]               in_ImmSrc,
    input  logic [address_width-1:0] in_base,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [address_width-1:0] out_instr,
    output logic [address_width-1:0] out_addr,
    output logic                     out_err
);

    localparam logic [2:0] SRC_I = 3'd0;
    localparam logic [2:0] SRC_S = 3'd1;
    localparam logic [2:0] SRC_B = 3'd2;
    localparam logic [2:0] SRC_U = 3'd3;
    localparam logic [2:0] SRC_J = 3'd4;

    localparam logic [address_width-1:0] FIRST_ADDR = address_width'(BASE_ADDR);
    localparam logic [address_width-1:0] LAST_ADDR  = address_width'(BASE_ADDR + 4 * (DEPTH - 1));

    // Scatter immediate bits into their format positions; everything else comes from the base word.
    function automatic logic [31:0] pack_imm(input logic [31:0] imm,
                                             input logic [2:0]  src,
                                             input logic [31:0] base);
        logic [31:0] w;
        w = base;
        case (src)
            SRC_I: w[31:20] = imm[11:0];
            SRC_S: begin
                w[31:25] = imm[11:5];
                w[11:7]  = imm[4:0];
            end
            SRC_B: begin
                w[31]    = imm[12];
                w[30:25] = imm[10:5];
                w[11:8]  = imm[4:1];
                w[7]     = imm[11];
            end
            SRC_U: w[31:12] = imm[31:12];
            SRC_J: begin
                w[31]    = imm[20];
                w[30:21] = imm[10:1];
                w[20]    = imm[11];
                w[19:12] = imm[19:12];
            end
            default: w = base;
        endcase
        return w;
    endfunction

`ifdef IMM_RANGE_CHECK_EN
    // An immediate fits when sign-extending its encodable bits reproduces it exactly.
    function automatic logic range_err(input logic [31:0] imm, input logic [2:0] src);
        logic err;
        case (src)
            SRC_I, SRC_S: err = (imm != {{20{imm[11]}}, imm[11:0]});
            SRC_B:        err = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
            SRC_U:        err = (imm[11:0] != 12'd0);
            SRC_J:        err = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
            default:      err = 1'b1;
        endcase
        return err;
    endfunction
`endif

    logic                     s1_valid;
    logic [address_width-1:0] s1_imm;
    logic [2:0]               s1_src;
    logic [address_width-1:0] s1_base;
`ifdef IMM_RANGE_CHECK_EN
    logic                     s1_err;
    logic                     s2_err;
`endif

    logic s2_free;
    logic s1_adv;
    logic accept;
    logic out_fire;

    always_comb begin
        s2_free  = !out_valid || out_ready;
        s1_adv   = s1_valid && s2_free;
        in_ready = !flush && (!s1_valid || s2_free);
        accept   = in_valid && in_ready;
        out_fire = out_valid && out_ready && !flush;
    end

    // Stage 1: capture the request and its range flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_imm   <= '0;
            s1_src   <= '0;
            s1_base  <= '0;
`ifdef IMM_RANGE_CHECK_EN
            s1_err   <= 1'b0;
`endif
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept || (s1_valid && !s1_adv);
            if (accept) begin
                s1_imm  <= in_imm;
                s1_src  <= in_ImmSrc;
                s1_base <= in_base;
`ifdef IMM_RANGE_CHECK_EN
                s1_err  <= range_err(in_imm, in_ImmSrc);
`endif
            end
        end
    end

    // Stage 2: merged word is held steady until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
`ifdef IMM_RANGE_CHECK_EN
            s2_err    <= 1'b0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= s1_adv || (out_valid && !out_ready);
            if (s1_adv) begin
                out_instr <= pack_imm(s1_imm, s1_src, s1_base);
`ifdef IMM_RANGE_CHECK_EN
                s2_err    <= s1_err;
`endif
            end
        end
    end

    // Write address advances per delivered word and wraps at the end of instruction memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr <= FIRST_ADDR;
        end else if (flush) begin
            out_addr <= FIRST_ADDR;
        end else if (out_fire) begin
            out_addr <= (out_addr == LAST_ADDR) ? FIRST_ADDR : out_addr + address_width'(4);
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    assign out_err = s2_err;
`else
    assign out_err = 1'b0;
`endif

endmodule
